servo_motion_ctrl: RTL and testbench
====================================

Name: servo_motion_ctrl

Overview:
Slew-rate-limited motion controller that drives the `angle_num` pulse-width input of the servo PWM generator on the 1 MHz domain.
- Accepts target pulse-width commands over a valid/ready handshake and clamps them to a safe range.
- Ramps the pulse width by at most STEP µs per 20 ms frame and updates only on frame boundaries.
- After arrival, dwells for a fixed number of frames, then signals done.
- Sits between the host/command logic and the servo PWM block.

Parameters:
FRAME_LEN, 20000, clk_1m cycles per PWM frame (20 ms).
PW_MIN, 500, minimum legal pulse width in µs/cycles.
PW_MAX, 2500, maximum legal pulse width.
PW_INIT, 1500, pulse width after reset (centre).
STEP, 20, maximum change of `angle_num` per frame.
DWELL, 2, frames held at target before done; legal range ≥1.

Ports:
clk_1m  input  1  1 MHz clock.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_pw  input  32  requested pulse width.
abort  input  1  stop motion, hold current width.
angle_num  output  32  pulse width to the servo PWM block.
frame_tick  output  1  one-cycle pulse at the last cycle of each frame.
busy  output  1  high in MOVE or SETTLE.
done  output  1  one-cycle pulse when dwell completes.
clamped  output  1  the last accepted command was clamped.

Behaviour:
- Reset values:
  - `angle_num` = PW_INIT, state = IDLE.
  - `cmd_ready`, `frame_tick`, `busy`, `done`, `clamped` all = 0 while `rst_n` is low.
  - Frame counter = 0; target = PW_INIT; dwell counter = 0.
- Frame counter:
  - Counts 0..FRAME_LEN-1 and wraps; free-running in all states.
  - `frame_tick` is asserted combinationally while count == FRAME_LEN-1.
  - Reset is shared with the PWM block, so frames are aligned.
- Register updates:
  - `angle_num` changes only on the clock edge where `frame_tick` = 1.
  - The new value is therefore valid from frame count 0 onward.
- States: IDLE, MOVE, SETTLE. `busy` = (state != IDLE). `cmd_ready` = (state == IDLE).
- IDLE:
  - A command is accepted on the edge where `cmd_valid` && `cmd_ready`.
  - target <= clamp(`cmd_pw`, PW_MIN, PW_MAX).
  - `clamped` <= (`cmd_pw` < PW_MIN || `cmd_pw` > PW_MAX); it is sticky until the next accept.
  - If the clamped target != `angle_num`, go to MOVE; otherwise go to SETTLE with dwell counter = 0.
  - `abort` is ignored in IDLE. If `abort` and `cmd_valid` are both high in IDLE, the command is accepted.
- MOVE, on each `frame_tick`:
  - If `angle_num` < target: `angle_num` <= min(`angle_num`+STEP, target).
  - If `angle_num` > target: `angle_num` <= max(`angle_num`-STEP, target).
  - When the new value equals target, go to SETTLE with dwell counter = 0.
  - All arithmetic is 32-bit unsigned. No overflow is possible because all values lie within [PW_MIN, PW_MAX].
- SETTLE:
  - The dwell counter increments on each `frame_tick`.
  - On the `frame_tick` where dwell counter == DWELL-1: `done` <= 1 for exactly one cycle (the next cycle), and state <= IDLE.
  - `cmd_ready` rises in that same next cycle.
- Abort:
  - In MOVE or SETTLE, `abort` high moves the state to IDLE on the next edge.
  - `angle_num` holds its current value and `done` is not pulsed.
  - `abort` has priority over a coincident `frame_tick` step or dwell completion: no step is applied and no `done` is generated.
- Command path: `cmd_valid` while not ready is held off by the requester. Commands are never queued or dropped silently.
- Reset mid-operation: any state returns immediately to reset values, and `angle_num` snaps to PW_INIT asynchronously.

Test Plan:
1. Reset, then command `cmd_pw`=1600 in IDLE → `angle_num` steps 1520, 1540, 1560, 1580, 1600 at 5 consecutive frame boundaries. `done` pulses 1 cycle after the 2nd subsequent `frame_tick`. `busy` falls and `cmd_ready` rises with `done`.
2. Command 1510 from 1500 → a single partial step to 1510, not 1520. Command 1495 from 1510 → step to 1495.
3. Command 3000 → target clamped to 2500 and `clamped`=1. Next command 1500 clears `clamped`. Command 100 → target 500 and `clamped`=1.
4. Command equal to the current width (1500 after reset) → no change to `angle_num`. SETTLE is entered directly and `done` fires after 2 frames.
5. Command 2000, assert `abort` mid-ramp at `angle_num`=1600, coincident with a `frame_tick` → `angle_num` stays 1600, IDLE next cycle, no `done`. `abort` in IDLE has no effect.
6. Assert `rst_n`=0 mid-MOVE at `angle_num`=1800 → immediately `angle_num`=1500, outputs 0. `cmd_valid` held during `busy` is not accepted until `cmd_ready`=1.

Source files
------------

// File: rtl/servo_motion_ctrl.sv
// Slew-rate-limited pulse-width controller for the servo PWM block. Targets are
// clamped, approached by at most STEP per frame, then held for DWELL frames.
module servo_motion_ctrl #(
  parameter int unsigned FRAME_LEN = 20000,
  parameter int unsigned PW_MIN    = 500,
  parameter int unsigned PW_MAX    = 2500,
  parameter int unsigned PW_INIT   = 1500,
  parameter int unsigned STEP      = 20,
  parameter int unsigned DWELL     = 2
) (
  input  logic        clk_1m,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_pw,
  input  logic        abort,
  output logic [31:0] angle_num,
  output logic        frame_tick,
  output logic        busy,
  output logic        done,
  output logic        clamped
);

  typedef enum logic [1:0] {StIdle, StMove, StSettle} state_e;

  state_e      state_q;
  logic [31:0] frame_cnt_q;
  logic [31:0] target_q;
  logic [31:0] dwell_q;
  logic [31:0] cmd_tgt;
  logic        cmd_oob;
  logic [31:0] step_up;
  logic [31:0] step_dn;
  logic [31:0] next_angle;

  always_comb begin
    // Gated by rst_n so handshake and tick outputs stay low throughout reset.
    frame_tick = rst_n && (frame_cnt_q == 32'(FRAME_LEN - 1));
    cmd_ready  = rst_n && (state_q == StIdle);
    busy       = (state_q != StIdle);

    cmd_oob = (cmd_pw < 32'(PW_MIN)) || (cmd_pw > 32'(PW_MAX));
    if (cmd_pw < 32'(PW_MIN)) begin
      cmd_tgt = 32'(PW_MIN);
    end else if (cmd_pw > 32'(PW_MAX)) begin
      cmd_tgt = 32'(PW_MAX);
    end else begin
      cmd_tgt = cmd_pw;
    end

    step_up    = (target_q - angle_num > 32'(STEP)) ? angle_num + 32'(STEP) : target_q;
    step_dn    = (angle_num - target_q > 32'(STEP)) ? angle_num - 32'(STEP) : target_q;
    next_angle = (angle_num < target_q) ? step_up : step_dn;
  end

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_tick) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      angle_num <= 32'(PW_INIT);
      target_q  <= 32'(PW_INIT);
      dwell_q   <= '0;
      done      <= 1'b0;
      clamped   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            target_q <= cmd_tgt;
            clamped  <= cmd_oob;
            dwell_q  <= '0;
            state_q  <= (cmd_tgt != angle_num) ? StMove : StSettle;
          end
        end
        StMove: begin
          // Abort wins over a coincident frame step.
          if (abort) begin
            state_q <= StIdle;
          end else if (frame_tick) begin
            angle_num <= next_angle;
            if (next_angle == target_q) begin
              state_q <= StSettle;
              dwell_q <= '0;
            end
          end
        end
        StSettle: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (frame_tick) begin
            if (dwell_q == 32'(DWELL - 1)) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              dwell_q <= dwell_q + 32'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Bench for servo_motion_ctrl: accepted commands push per-frame expected events into a
// scoreboard queue; a negedge monitor pops one event per frame boundary and compares.
module tb_servo_motion_ctrl;

  localparam int FL      = 16;
  localparam int PW_MIN  = 500;
  localparam int PW_MAX  = 2500;
  localparam int PW_INIT = 1500;
  localparam int STEP    = 20;
  localparam int DWELL   = 2;
  // Event codes: value >= 0 is the width expected at that boundary.
  localparam int EvDwell = -1;
  localparam int EvDone  = -2;

  logic        clk_1m = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_pw = '0;
  logic        abort = 1'b0;
  logic [31:0] angle_num;
  logic        frame_tick;
  logic        busy;
  logic        done;
  logic        clamped;

  int tests = 0;
  int fails = 0;

  servo_motion_ctrl #(
    .FRAME_LEN(FL),
    .PW_MIN   (PW_MIN),
    .PW_MAX   (PW_MAX),
    .PW_INIT  (PW_INIT),
    .STEP     (STEP),
    .DWELL    (DWELL)
  ) dut (
    .clk_1m    (clk_1m),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_pw    (cmd_pw),
    .abort     (abort),
    .angle_num (angle_num),
    .frame_tick(frame_tick),
    .busy      (busy),
    .done      (done),
    .clamped   (clamped)
  );

  always #5 clk_1m = ~clk_1m;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the walk from cur toward tgt in STEP-sized hops, then dwell frames.
  int exp_q[$];
  int model_cur = PW_INIT;

  function automatic void push_path(input int cur, input int tgt);
    int c = cur;
    while (c != tgt) begin
      if (tgt > c) c = (tgt - c > STEP) ? c + STEP : tgt;
      else         c = (c - tgt > STEP) ? c - STEP : tgt;
      exp_q.push_back(c);
    end
    for (int i = 0; i < DWELL - 1; i++) exp_q.push_back(EvDwell);
    exp_q.push_back(EvDone);
  endfunction

  // Edge sampler: what the DUT saw at the active edge.
  logic e_ft = 1'b0, e_acc = 1'b0, e_abort = 1'b0;
  int   e_pw = 0;
  int   k = 0;

  always @(posedge clk_1m) begin
    if (!rst_n) begin
      e_ft = 1'b0; e_acc = 1'b0; e_abort = 1'b0; k = 0;
    end else begin
      e_ft    = frame_tick;
      e_acc   = cmd_valid && cmd_ready;
      e_abort = abort && busy;
      e_pw    = int'(cmd_pw);
      k++;
    end
  end

  int prev_angle = PW_INIT;

  always @(negedge clk_1m) begin
    int e;
    int tgt;
    if (!rst_n) begin
      exp_q.delete();
      model_cur = PW_INIT;
    end else begin
      if ((k % FL == FL - 1) || frame_tick)
        chk("frame_tick_period", int'(frame_tick), int'(k % FL == FL - 1));
      if (e_abort) begin
        exp_q.delete();
        chk("abort_hold", int'(angle_num), prev_angle);
        chk("abort_no_done", int'(done), 0);
        chk("abort_ready", int'(cmd_ready), 1);
      end else if (e_ft && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e >= 0) begin
          chk("step_value", int'(angle_num), e);
          chk("step_busy", int'(busy), 1);
          chk("step_no_done", int'(done), 0);
          model_cur = e;
        end else if (e == EvDwell) begin
          chk("dwell_hold", int'(angle_num), prev_angle);
          chk("dwell_no_done", int'(done), 0);
        end else begin
          chk("done_pulse", int'(done), 1);
          chk("done_ready", int'(cmd_ready), 1);
          chk("done_busy", int'(busy), 0);
          chk("done_hold", int'(angle_num), prev_angle);
        end
      end else if (int'(angle_num) != prev_angle || done) begin
        chk("spurious_change", int'(angle_num), prev_angle);
        chk("spurious_done", int'(done), 0);
      end
      if (e_acc) begin
        tgt = (e_pw < PW_MIN) ? PW_MIN : (e_pw > PW_MAX) ? PW_MAX : e_pw;
        chk("clamped_flag", int'(clamped), int'(e_pw < PW_MIN || e_pw > PW_MAX));
        chk("accept_busy", int'(busy), 1);
        push_path(model_cur, tgt);
      end
    end
    prev_angle = int'(angle_num);
  end

  task automatic send(input int pw);
    int n = 0;
    @(negedge clk_1m);
    cmd_valid = 1'b1;
    cmd_pw    = 32'(pw);
    while (!cmd_ready && n < 5000) begin
      @(negedge clk_1m);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    @(posedge clk_1m);
    @(negedge clk_1m);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk_1m);
      n++;
    end
    if (!cmd_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_angle(input int a, input bool_tick);
    int n = 0;
    while (!(int'(angle_num) == a && frame_tick == bool_tick) && n < 5000) begin
      @(negedge clk_1m);
      n++;
    end
    if (n >= 5000) chk("wait_angle_timeout", int'(angle_num), a);
  endtask

  task automatic reset_and_check();
    @(posedge clk_1m);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_angle", int'(angle_num), PW_INIT);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_clamped", int'(clamped), 0);
    chk("rst_tick", int'(frame_tick), 0);
    repeat (3) @(posedge clk_1m);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int pw;
    int r;
    reset_and_check();
    send(1500);                // equal to current width: dwell only
    wait_idle();
    send(1600);
    wait_idle();
    send(1510);
    wait_idle();
    send(1495);
    wait_idle();
    send(3000);
    wait_idle();
    send(1500);
    wait_idle();
    send(100);
    wait_idle();
    send(1500);
    wait_idle();
    send(2000);
    wait_angle(1600, 1'b1);    // abort coincident with a frame tick
    abort = 1'b1;
    @(negedge clk_1m);
    abort = 1'b0;
    chk("abort_angle_1600", int'(angle_num), 1600);
    abort = 1'b1;              // abort in idle must not block the command
    send(1900);
    abort = 1'b0;
    wait_idle();
    send(1500);
    wait_angle(1800, 1'b0);
    reset_and_check();
    send(1700);
    send(1300);                // valid held while busy
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      pw = int'($urandom_range(0, 499));
      else if (r == 1) pw = int'($urandom_range(2501, 4000));
      else             pw = int'($urandom_range(1300, 1700));
      send(pw);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 150)) @(negedge clk_1m);
        if (busy) begin
          abort = 1'b1;
          @(negedge clk_1m);
          abort = 1'b0;
        end
      end
      wait_idle();
    end
    repeat (2 * FL) @(negedge clk_1m);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
